// File: rtl/alarm_pkg.sv
// Shared codes for the security-chip alarm FSM and its response-side companion.
package alarm_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2,
    ST_ALARM_ON  = 2'd3
  } fsm_state_e;

  typedef enum logic [2:0] {
    RS_IDLE    = 3'd0,
    RS_WARN    = 3'd1,
    RS_GRACE   = 3'd2,
    RS_SIREN   = 3'd3,
    RS_LOCKOUT = 3'd4
  } resp_state_e;

endpackage

// File: rtl/code_checker.sv
// Two-digit keypad code checker: digit buffer, pending flag, compare against CODE
// and a saturating 3-bit wrong-code counter.
module code_checker
  import alarm_pkg::*;
#(
  parameter logic [2*DIGIT_W-1:0] CODE = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  output logic               match_pulse,
  output logic               mismatch_pulse,
  output logic [2:0]         fail_cnt
);

  logic               pending_reg;
  logic [DIGIT_W-1:0] first_reg;
  logic [2:0]         fail_cnt_reg;
  logic               complete;

  // A strobe while a first digit is pending completes an attempt.
  assign complete       = en && key_valid && pending_reg;
  assign match_pulse    = complete && ({first_reg, key_digit} == CODE);
  assign mismatch_pulse = complete && ({first_reg, key_digit} != CODE);
  assign fail_cnt       = fail_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg  <= 1'b0;
      first_reg    <= '0;
      fail_cnt_reg <= 3'd0;
    end else begin
      if (clr) begin
        pending_reg <= 1'b0;
        first_reg   <= '0;
      end else if (en && key_valid) begin
        if (!pending_reg) begin
          first_reg   <= key_digit;
          pending_reg <= 1'b1;
        end else begin
          first_reg   <= '0;
          pending_reg <= 1'b0;
        end
      end

      if (match_pulse) begin
        fail_cnt_reg <= 3'd0;
      end else if (mismatch_pulse && (fail_cnt_reg != 3'd7)) begin
        fail_cnt_reg <= fail_cnt_reg + 3'd1;
      end
    end
  end

endmodule

// File: rtl/alarm_responder.sv
// Annunciator side of the alarm: warning beep, grace period, siren and keypad disarm.
// Optional wrong-code lockout is enabled by defining RESPONDER_LOCKOUT_EN.
module alarm_responder
  import alarm_pkg::*;
#(
  parameter int                   GRACE_CYCLES = 16,
  parameter int                   BEEP_HALF    = 4,
  parameter logic [2*DIGIT_W-1:0] CODE         = 8'hA5,
  parameter int                   MAX_TRIES    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alarm_in,
  input  logic [1:0]         state_in,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  output logic               siren,
  output logic               beep,
  output logic               disarm_req,
  output logic               lockout,
  output logic [2:0]         resp_state
);

  localparam int GRACE_W = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;
  localparam int BEEP_W  = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

  resp_state_e        state_reg, state_next;
  logic [GRACE_W-1:0] grace_cnt_reg;
  logic [BEEP_W-1:0]  beep_cnt_reg;
  logic               siren_reg, beep_reg, disarm_req_reg, lockout_reg;
  logic               key_en, clr_buf, ext_reset, lock_hit;
  logic               match_pulse, mismatch_pulse;
  logic [2:0]         fail_cnt;

  assign key_en    = (state_reg == RS_WARN) || (state_reg == RS_GRACE) || (state_reg == RS_SIREN);
  assign ext_reset = !alarm_in && (state_in != ST_ALARM_ON);
  assign clr_buf   = (state_next == RS_IDLE) && (state_reg != RS_IDLE);

  code_checker #(
    .CODE(CODE)
  ) u_code_checker (
    .clk           (clk),
    .rst           (rst),
    .en            (key_en),
    .clr           (clr_buf),
    .key_valid     (key_valid),
    .key_digit     (key_digit),
    .match_pulse   (match_pulse),
    .mismatch_pulse(mismatch_pulse),
    .fail_cnt      (fail_cnt)
  );

`ifdef RESPONDER_LOCKOUT_EN
  // The fail count has not yet been bumped for the attempt completing now.
  assign lock_hit = mismatch_pulse && (fail_cnt >= 3'(MAX_TRIES - 1));
`else
  logic unused_lock;
  assign lock_hit    = 1'b0;
  assign unused_lock = mismatch_pulse ^ (^fail_cnt) ^ (fail_cnt >= 3'(MAX_TRIES - 1));
`endif

  // A correct code has priority over every other event, including grace expiry.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RS_IDLE: begin
        if (alarm_in)                       state_next = RS_GRACE;
        else if (state_in == ST_TRIGGERED)  state_next = RS_WARN;
      end
      RS_WARN: begin
        if (match_pulse)                    state_next = RS_IDLE;
        else if (lock_hit)                  state_next = RS_LOCKOUT;
        else if (alarm_in)                  state_next = RS_GRACE;
        else if ((state_in == ST_OFF) || (state_in == ST_ARMED))
                                            state_next = RS_IDLE;
      end
      RS_GRACE: begin
        if (match_pulse)                    state_next = RS_IDLE;
        else if (lock_hit)                  state_next = RS_LOCKOUT;
        else if (ext_reset)                 state_next = RS_IDLE;
        else if (grace_cnt_reg == '0)       state_next = RS_SIREN;
      end
      RS_SIREN: begin
        if (match_pulse)                    state_next = RS_IDLE;
        else if (lock_hit)                  state_next = RS_LOCKOUT;
        else if (ext_reset)                 state_next = RS_IDLE;
      end
      RS_LOCKOUT: state_next = RS_LOCKOUT;
      default:    state_next = RS_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= RS_IDLE;
      grace_cnt_reg  <= '0;
      beep_cnt_reg   <= '0;
      siren_reg      <= 1'b0;
      beep_reg       <= 1'b0;
      disarm_req_reg <= 1'b0;
      lockout_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;

      if ((state_next == RS_GRACE) && (state_reg != RS_GRACE)) begin
        grace_cnt_reg <= GRACE_W'(GRACE_CYCLES - 1);
      end else if ((state_reg == RS_GRACE) && (grace_cnt_reg != '0)) begin
        grace_cnt_reg <= grace_cnt_reg - 1'b1;
      end

      if (state_next == RS_WARN) begin
        if (state_reg != RS_WARN) begin
          beep_cnt_reg <= '0;
          beep_reg     <= 1'b0;
        end else if (beep_cnt_reg == BEEP_W'(BEEP_HALF - 1)) begin
          beep_cnt_reg <= '0;
          beep_reg     <= ~beep_reg;
        end else begin
          beep_cnt_reg <= beep_cnt_reg + 1'b1;
        end
      end else begin
        beep_cnt_reg <= '0;
        beep_reg     <= (state_next == RS_GRACE);
      end

      siren_reg      <= (state_next == RS_SIREN) || (state_next == RS_LOCKOUT);
      lockout_reg    <= (state_next == RS_LOCKOUT);
      disarm_req_reg <= match_pulse;
    end
  end

  assign siren      = siren_reg;
  assign beep       = beep_reg;
  assign disarm_req = disarm_req_reg;
  assign lockout    = lockout_reg;
  assign resp_state = state_reg;

endmodule

// File: tb/tb_alarm_responder.sv
// Directed self-checking bench for alarm_responder (default parameters).
module tb_alarm_responder;

  logic       clk;
  logic       rst;
  logic       alarm_in;
  logic [1:0] state_in;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       siren, beep, disarm_req, lockout;
  logic [2:0] resp_state;

  int checks = 0;
  int errors = 0;

  alarm_responder dut (
    .clk       (clk),
    .rst       (rst),
    .alarm_in  (alarm_in),
    .state_in  (state_in),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .siren     (siren),
    .beep      (beep),
    .disarm_req(disarm_req),
    .lockout   (lockout),
    .resp_state(resp_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    tick(1);
    key_valid = 1'b0;
    key_digit = 4'h0;
  endtask

  task automatic test_reset;
    tick(1);
    checks++;
    if ({siren, beep, disarm_req, lockout, resp_state} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got s=%b b=%b d=%b l=%b st=%0d, want all 0",
               siren, beep, disarm_req, lockout, resp_state);
    end
    rst = 1'b0;
    tick(1);
    checks++;
    if (resp_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle: resp_state=%0d want 0", resp_state);
    end
    $display("test_reset done");
  endtask

  task automatic test_warn_beep;
    logic exp_beep;
    state_in = 2'd2;
    tick(1);
    checks++;
    if (resp_state !== 3'd1) begin
      errors++;
      $display("FAIL warn_entry: resp_state=%0d want 1", resp_state);
    end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick(1);
      exp_beep = ((i / 4) % 2) == 1;
      checks++;
      if (beep !== exp_beep || siren !== 1'b0) begin
        errors++;
        $display("FAIL warn_beep cyc %0d: beep=%b siren=%b want beep=%b siren=0",
                 i, beep, siren, exp_beep);
      end
    end
    state_in = 2'd0;
    tick(1);
    checks++;
    if (resp_state !== 3'd0 || beep !== 1'b0) begin
      errors++;
      $display("FAIL warn_exit: resp_state=%0d beep=%b want 0 0", resp_state, beep);
    end
    $display("test_warn_beep done");
  endtask

  task automatic test_grace_siren;
    logic exp_siren;
    alarm_in = 1'b1;
    state_in = 2'd3;
    tick(1);
    checks++;
    if (resp_state !== 3'd2 || beep !== 1'b1 || siren !== 1'b0) begin
      errors++;
      $display("FAIL grace_entry: st=%0d beep=%b siren=%b want 2 1 0", resp_state, beep, siren);
    end
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      exp_siren = (i == 16);
      checks++;
      if (siren !== exp_siren || beep !== !exp_siren) begin
        errors++;
        $display("FAIL grace_siren cyc %0d: siren=%b beep=%b want siren=%b beep=%b",
                 i, siren, beep, exp_siren, !exp_siren);
      end
    end
    checks++;
    if (resp_state !== 3'd3) begin
      errors++;
      $display("FAIL siren_state: resp_state=%0d want 3", resp_state);
    end
    $display("test_grace_siren done");
  endtask

  task automatic test_disarm;
    key(4'hA);
    checks++;
    if (disarm_req !== 1'b0 || siren !== 1'b1) begin
      errors++;
      $display("FAIL disarm_first_digit: disarm=%b siren=%b want 0 1", disarm_req, siren);
    end
    key(4'h5);
    checks++;
    if (disarm_req !== 1'b1 || siren !== 1'b0 || resp_state !== 3'd0) begin
      errors++;
      $display("FAIL disarm_pulse: disarm=%b siren=%b st=%0d want 1 0 0",
               disarm_req, siren, resp_state);
    end
    alarm_in = 1'b0;
    state_in = 2'd0;
    tick(1);
    checks++;
    if (disarm_req !== 1'b0 || resp_state !== 3'd0) begin
      errors++;
      $display("FAIL disarm_single: disarm=%b st=%0d want 0 0", disarm_req, resp_state);
    end
    $display("test_disarm done");
  endtask

  task automatic test_lockout;
    logic       exp_lock;
    logic [2:0] exp_st;
    alarm_in = 1'b1;
    state_in = 2'd3;
    tick(17);
    checks++;
    if (siren !== 1'b1) begin
      errors++;
      $display("FAIL lock_siren_on: siren=%b want 1", siren);
    end
    for (int p = 0; p < 3; p++) begin
      key(4'h1);
      key(4'h2);
`ifdef RESPONDER_LOCKOUT_EN
      exp_lock = (p == 2);
`else
      exp_lock = 1'b0;
`endif
      exp_st = exp_lock ? 3'd4 : 3'd3;
      checks++;
      if (lockout !== exp_lock || resp_state !== exp_st || siren !== 1'b1 || disarm_req !== 1'b0) begin
        errors++;
        $display("FAIL wrong_pair %0d: lockout=%b st=%0d siren=%b disarm=%b want %b %0d 1 0",
                 p, lockout, resp_state, siren, disarm_req, exp_lock, exp_st);
      end
    end
`ifdef RESPONDER_LOCKOUT_EN
    key(4'hA);
    key(4'h5);
    checks++;
    if (disarm_req !== 1'b0 || resp_state !== 3'd4 || lockout !== 1'b1) begin
      errors++;
      $display("FAIL lockout_ignores_keys: disarm=%b st=%0d lockout=%b want 0 4 1",
               disarm_req, resp_state, lockout);
    end
`endif
    rst = 1'b1;
    #1;
    checks++;
    if ({siren, beep, disarm_req, lockout, resp_state} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset_siren: s=%b b=%b d=%b l=%b st=%0d want all 0",
               siren, beep, disarm_req, lockout, resp_state);
    end
    alarm_in = 1'b0;
    state_in = 2'd0;
    tick(1);
    rst = 1'b0;
    tick(1);
    checks++;
    if (resp_state !== 3'd0 || siren !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: st=%0d siren=%b want 0 0", resp_state, siren);
    end
    $display("test_lockout done");
  endtask

  task automatic test_grace_expiry_disarm;
    logic seen_siren;
    seen_siren = 1'b0;
    alarm_in = 1'b1;
    state_in = 2'd3;
    tick(1);
    for (int i = 1; i <= 14; i++) begin
      tick(1);
      seen_siren = seen_siren | siren;
    end
    key(4'hA);
    seen_siren = seen_siren | siren;
    key(4'h5);
    seen_siren = seen_siren | siren;
    checks++;
    if (disarm_req !== 1'b1 || resp_state !== 3'd0 || seen_siren !== 1'b0) begin
      errors++;
      $display("FAIL expiry_disarm: disarm=%b st=%0d siren_seen=%b want 1 0 0",
               disarm_req, resp_state, seen_siren);
    end
    alarm_in = 1'b0;
    state_in = 2'd0;
    tick(1);
    checks++;
    if (siren !== 1'b0 || disarm_req !== 1'b0 || resp_state !== 3'd0) begin
      errors++;
      $display("FAIL expiry_after: siren=%b disarm=%b st=%0d want 0 0 0",
               siren, disarm_req, resp_state);
    end
    $display("test_grace_expiry_disarm done");
  endtask

  task automatic test_reset_mid_entry;
    state_in = 2'd2;
    tick(1);
    key(4'hA);
    checks++;
    if (disarm_req !== 1'b0 || resp_state !== 3'd1) begin
      errors++;
      $display("FAIL mid_entry_first: disarm=%b st=%0d want 0 1", disarm_req, resp_state);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (resp_state !== 3'd0 || beep !== 1'b0) begin
      errors++;
      $display("FAIL mid_entry_async: st=%0d beep=%b want 0 0", resp_state, beep);
    end
    tick(1);
    rst = 1'b0;
    tick(1);
    checks++;
    if (resp_state !== 3'd1) begin
      errors++;
      $display("FAIL mid_entry_rewarn: st=%0d want 1", resp_state);
    end
    key(4'h5);
    checks++;
    if (disarm_req !== 1'b0 || resp_state !== 3'd1) begin
      errors++;
      $display("FAIL mid_entry_no_disarm: disarm=%b st=%0d want 0 1", disarm_req, resp_state);
    end
    tick(1);
    checks++;
    if (disarm_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_entry_no_disarm_late: disarm=%b want 0", disarm_req);
    end
    state_in = 2'd0;
    tick(1);
    $display("test_reset_mid_entry done");
  endtask

  initial begin
    rst       = 1'b1;
    alarm_in  = 1'b0;
    state_in  = 2'd0;
    key_valid = 1'b0;
    key_digit = 4'h0;
    test_reset();
    test_warn_beep();
    test_grace_siren();
    test_disarm();
    test_lockout();
    test_grace_expiry_disarm();
    test_reset_mid_entry();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
